bin2dec_tx: RTL and testbench
=============================

BIN2DEC_TX -- requirements
Module: bin2dec_tx

Interface
REQ-001 SHALL have parameter W, default 32, result width in bits.
REQ-002 SHALL have parameter DIG, default 10, number of BCD digits (ceil(W*log10(2))).
REQ-003 SHALL have parameter TERM_EN, default 1, append CR LF after each number when 1.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port result  input  W  ALU product to print.
REQ-007 SHALL have port done  input  1  one-cycle pulse, result valid this cycle.
REQ-008 SHALL have port sgn  input  1  1 = result is two's complement, sampled with done.
REQ-009 SHALL have port tx_data  output  8  ASCII byte to UART TX.
REQ-010 SHALL have port tx_valid  output  1  tx_data valid.
REQ-011 SHALL have port tx_ready  input  1  UART TX accepts byte.
REQ-012 SHALL have port busy  output  1  high from capture until last byte accepted.
REQ-013 SHALL have port ovr  output  1  one-cycle pulse, done dropped while busy.

Function
REQ-014 SHALL implement FSM states IDLE, CONV, SIGN, DIGIT, CR, LF.
REQ-015 IDLE: on done=1, SHALL capture magnitude (sgn&&result[W-1] ? -result : result) and a neg flag, clear BCD register, load step counter W, go to CONV.
REQ-016 CONV: SHALL perform one double-dabble step per cycle (add 3 to every digit >=5, then shift left 1) for exactly W cycles.
REQ-017 CONV exit: SHALL go to SIGN if neg, otherwise DIGIT; digit index SHALL be the most significant nonzero digit, or digit 0 when value is 0.
REQ-018 tx_valid SHALL first rise W+1 rising edges after the edge sampling done (33 for W=32).
REQ-019 SIGN SHALL present 0x2D ('-'); DIGIT SHALL present 0x30+digit[index]; CR presents 0x0D; LF presents 0x0A.
REQ-020 Transfer occurs only on an edge with tx_valid=1 and tx_ready=1; tx_data and tx_valid SHALL stay stable until then.
REQ-021 After transfer: SIGN->DIGIT; DIGIT decrements index, after index 0 -> CR (TERM_EN=1) or IDLE (TERM_EN=0); CR->LF; LF->IDLE.
REQ-022 tx_valid SHALL be 0 in IDLE and CONV; busy SHALL be 1 in every state except IDLE.
REQ-023 done while busy=1 SHALL be ignored and SHALL pulse ovr for exactly one cycle; conversion in progress SHALL be unaffected.
REQ-024 done in the same cycle as the final (LF) transfer SHALL be treated as busy (ignored, ovr pulse).
REQ-025 Signed -2^(W-1) SHALL print correctly (magnitude fits unsigned W bits).

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, tx_valid=0, tx_data=0x00, busy=0, ovr=0, clear BCD, shift, counter and index registers.
REQ-027 rst mid-CONV or mid-transmission SHALL abort with no further bytes; the first done after rst release SHALL be processed normally.

Structure
REQ-028 A shared package SHALL hold the state encoding and ASCII constants (0x30, 0x2D, 0x0D, 0x0A).
REQ-029 One sub-module dd_step SHALL implement a combinational double-dabble step (DIG digits + shift input bit), instantiated once.

Verification
REQ-030 result=0x0000_0000, sgn=0, tx_ready=1 -> bytes 0x30,0x0D,0x0A; busy low after LF.
REQ-031 result=0xFFFF_FFFF, sgn=0 -> "4294967295" CR LF (12 bytes); tx_valid rises exactly 33 edges after done.
REQ-032 result=0x8000_0000, sgn=1 -> "-2147483648" CR LF; same value with sgn=0 -> "2147483648" CR LF.
REQ-033 result=0x0000_007B, tx_ready low 5 cycles before each accept -> 0x31,0x32,0x33,0x0D,0x0A, tx_data stable during every stall.
REQ-034 second done 10 cycles after first -> ovr high one cycle, output stream of first value unchanged, no extra bytes.
REQ-035 rst asserted during CONV and again during DIGIT -> next cycle tx_valid=0, busy=0; following done with result=0x0000_0005 -> 0x35,0x0D,0x0A.

Source files
------------

// File: rtl/bin2dec_tx_pkg.sv
// Shared state encoding and ASCII constants for the binary-to-decimal UART printer.
// Purely declarative; no logic, no latency, no flow control.
// Imported by bin2dec_tx.
package bin2dec_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_SIGN,
        S_DIGIT,
        S_CR,
        S_LF
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

endpackage

// File: rtl/bin2dec_tx_dd_step.sv
// One double-dabble step: add 3 to every BCD digit >= 5, then shift left by one bit.
// Combinational, zero latency.
// No flow control; the caller decides when to register the result.
module dd_step #(
    parameter int DIG = 10
) (
    input  logic [4*DIG-1:0] bcd_in,
    input  logic             shift_in,
    output logic [4*DIG-1:0] bcd_out
);

    logic [4*DIG-1:0] adj;

    always_comb begin
        adj = '0;
        for (int i = 0; i < DIG; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            else
                adj[4*i +: 4] = bcd_in[4*i +: 4];
        end
    end

    assign bcd_out = {adj[4*DIG-2:0], shift_in};

endmodule

// File: rtl/bin2dec_tx.sv
// Prints a W-bit result as ASCII decimal (optional '-', optional CR LF) to a UART TX.
// First byte is valid W+1 cycles after done; one byte per accepted handshake after that.
// Holds tx_data/tx_valid until tx_ready; done arriving while busy is dropped and flagged on ovr.
module bin2dec_tx
    import bin2dec_tx_pkg::*;
#(
    parameter int W       = 32,
    parameter int DIG     = 10,
    parameter int TERM_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] result,
    input  logic         done,
    input  logic         sgn,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy,
    output logic         ovr
);

    localparam int IW = (DIG > 1) ? $clog2(DIG) : 1;
    localparam int CW = $clog2(W + 1);

    state_t              state_q, state_d;
    logic [W-1:0]        shreg_q;
    logic [DIG-1:0][3:0] bcd_q;
    logic [4*DIG-1:0]    bcd_step;
    logic [CW-1:0]       cnt_q;
    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       top_idx;
    logic                neg_q;
    logic                ovr_q;
    logic                is_neg;

    dd_step #(.DIG(DIG)) u_dd_step (
        .bcd_in   (bcd_q),
        .shift_in (shreg_q[W-1]),
        .bcd_out  (bcd_step)
    );

    assign is_neg = sgn && result[W-1];
    assign busy   = (state_q != S_IDLE);
    assign ovr    = ovr_q;

    // Most significant nonzero digit; a zero value still prints digit 0.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < DIG; i++) begin
            if (bcd_q[i] != 4'd0)
                top_idx = IW'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (done)
                    state_d = S_CONV;
            end
            S_CONV: begin
                if (cnt_q == '0)
                    state_d = neg_q ? S_SIGN : S_DIGIT;
            end
            S_SIGN: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_MINUS;
                if (tx_ready)
                    state_d = S_DIGIT;
            end
            S_DIGIT: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_ZERO + {4'h0, bcd_q[idx_q]};
                if (tx_ready && idx_q == '0)
                    state_d = (TERM_EN != 0) ? S_CR : S_IDLE;
            end
            S_CR: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_CR;
                if (tx_ready)
                    state_d = S_LF;
            end
            S_LF: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_LF;
                if (tx_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            neg_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= done && busy;
            case (state_q)
                S_IDLE: begin
                    if (done) begin
                        // Two's-complement negate; -2^(W-1) maps onto itself, which is the right magnitude.
                        shreg_q <= is_neg ? -result : result;
                        neg_q   <= is_neg;
                        bcd_q   <= '0;
                        cnt_q   <= CW'(W);
                    end
                end
                S_CONV: begin
                    if (cnt_q != '0) begin
                        bcd_q   <= bcd_step;
                        shreg_q <= shreg_q << 1;
                        cnt_q   <= cnt_q - 1'b1;
                    end else begin
                        idx_q   <= top_idx;
                    end
                end
                S_DIGIT: begin
                    if (tx_ready && idx_q != '0)
                        idx_q <= idx_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2dec_tx.sv
// Directed bench for bin2dec_tx: hand-computed ASCII streams, latency, stalls, overrun and reset abort.
module tb_bin2dec_tx;

    logic        clk;
    logic        rst;
    logic [31:0] result;
    logic        done;
    logic        sgn;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        ovr;

    int n_checks;
    int n_pass;

    bin2dec_tx #(.W(32), .DIG(10), .TERM_EN(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .result   (result),
        .done     (done),
        .sgn      (sgn),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .ovr      (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // mode 0: plain; 1: extra done 10 cycles into conversion; 2: extra done alongside the LF transfer
    task automatic send(input logic [31:0] val, input logic s, input int stall,
                        input string exp_str, input int exp_lat, input int mode);
        int lat;
        int t;
        int stable_err;
        logic [7:0] held;
        @(negedge clk);
        result   = val;
        sgn      = s;
        done     = 1'b1;
        tx_ready = (stall == 0);
        @(negedge clk);
        done = 1'b0;
        check("busy_after_done", 32'(busy), 32'd1);
        lat = 0;
        while (!tx_valid && lat < 200) begin
            @(negedge clk);
            lat++;
            if (mode == 1 && lat == 10) begin
                done   = 1'b1;
                result = 32'd999;
            end else if (mode == 1 && lat == 11) begin
                done = 1'b0;
                check("ovr_pulse", 32'(ovr), 32'd1);
            end else if (mode == 1 && lat == 12) begin
                check("ovr_one_cycle", 32'(ovr), 32'd0);
            end
        end
        if (exp_lat > 0)
            check("latency", 32'(lat), 32'(exp_lat));
        stable_err = 0;
        for (int k = 0; k < exp_str.len(); k++) begin
            t = 0;
            while (!tx_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("valid%0d", k), 32'(tx_valid), 32'd1);
            held = tx_data;
            for (int c = 0; c < stall; c++) begin
                @(negedge clk);
                if (tx_data !== held || tx_valid !== 1'b1)
                    stable_err++;
            end
            tx_ready = 1'b1;
            check($sformatf("byte%0d", k), 32'(tx_data), 32'(exp_str[k]));
            if (mode == 2 && k == exp_str.len() - 1) begin
                done   = 1'b1;
                result = 32'd5;
            end
            @(negedge clk);
            done     = 1'b0;
            tx_ready = (stall == 0);
        end
        if (stall > 0)
            check("stall_stable", 32'(stable_err), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("valid_end", 32'(tx_valid), 32'd0);
        if (mode == 2) begin
            check("ovr_at_lf", 32'(ovr), 32'd1);
            @(negedge clk);
            check("lf_done_ignored", 32'(busy), 32'd0);
        end
    endtask

    task automatic reset_and_check(input string tag);
        int extra;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        rst      = 1'b0;
        tx_ready = 1'b1;
        extra    = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tx_valid)
                extra++;
        end
        check({tag, "_no_bytes"}, 32'(extra), 32'd0);
    endtask

    initial begin
        int t;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        done     = 1'b0;
        result   = '0;
        sgn      = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        rst = 1'b0;

        send(32'h0000_0000, 1'b0, 0, "0\r\n", 33, 0);
        send(32'hFFFF_FFFF, 1'b0, 0, "4294967295\r\n", 33, 0);
        send(32'h8000_0000, 1'b1, 0, "-2147483648\r\n", 33, 0);
        send(32'h8000_0000, 1'b0, 0, "2147483648\r\n", 33, 0);
        send(32'hFFFF_FF85, 1'b1, 0, "-123\r\n", 0, 0);
        send(32'h0000_007B, 1'b0, 5, "123\r\n", 0, 0);
        send(32'h0000_007B, 1'b0, 0, "123\r\n", 33, 1);
        send(32'd1000000, 1'b0, 0, "1000000\r\n", 0, 2);

        // Abort mid-conversion.
        @(negedge clk);
        result = 32'hFFFF_FFFF;
        sgn    = 1'b0;
        done   = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (10) @(negedge clk);
        reset_and_check("rst_conv");

        // Abort while the digits are being sent.
        @(negedge clk);
        result = 32'hFFFF_FFFF;
        done   = 1'b1;
        @(negedge clk);
        done = 1'b0;
        t = 0;
        while (!tx_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check("mid_digit_valid", 32'(tx_valid), 32'd1);
        reset_and_check("rst_digit");

        send(32'h0000_0005, 1'b0, 0, "5\r\n", 33, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
